// File: rtl/sdram_responder_pkg.sv
// Shared constants and types for the simulation-side SDRAM responder.
package sdram_responder_pkg;

  // Width of the data field carried by a read-pipeline entry.
  localparam int DATA_W = 32;

  // Returned for reads that fall outside the mapped window.
  localparam logic [DATA_W-1:0] BAD_READ_DATA = 32'hDEADBEEF;

  // Word address of array index 0 (byte address 0x3E000000 >> 2).
  localparam logic [29:0] DEFAULT_BASE_WORD = 30'h0F800000;

  // Stall generator: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One slot of the fixed-latency read pipeline.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_entry_t;

endpackage

// File: rtl/sdram_read_pipe.sv
// Fixed-latency shift pipeline for read responses. The valid bit shifts every
// cycle; a stage's data only moves when a valid entry arrives, so the output
// data holds the last returned word between pulses. flush clears everything.
module sdram_read_pipe
  import sdram_responder_pkg::*;
#(
  parameter int READ_LATENCY = 4
) (
  input  logic      clock,
  input  logic      flush,
  input  rd_entry_t in_entry,
  output rd_entry_t out_entry
);

  rd_entry_t stage [READ_LATENCY];

  // Shift entries one stage per cycle; flush drops every in-flight response.
  always_ff @(posedge clock) begin
    if (flush) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= in_entry.valid;
      if (in_entry.valid) begin
        stage[0].data <= in_entry.data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage[i].valid <= stage[i-1].valid;
        if (stage[i-1].valid) begin
          stage[i].data <= stage[i-1].data;
        end
      end
    end
  end

  assign out_entry = stage[READ_LATENCY-1];

endmodule

// File: rtl/sdram_responder.sv
// Avalon-MM responder standing in for the SDRAM behind the GPU master port.
// Word-array backing store, waitrequest back-pressure, in-order pipelined
// read data READ_LATENCY cycles after acceptance.
// Optional build macro SDRAM_RESPONDER_STALL_EN adds LFSR-driven random stalls.
//
// Handshake: a request is accepted in any cycle where the master holds
// read or write high while waitrequest is low. waitrequest is a function of
// reset and registered state only. Each accepted read returns exactly one
// readdatavalid pulse, in order; writes return nothing. Read and write
// together performs the write, drops the read and flags protocol_error.
module sdram_responder
  import sdram_responder_pkg::*;
#(
  parameter int          WORD_WIDTH     = 32,
  parameter int          MEM_WORDS_LOG2 = 16,
  parameter logic [29:0] BASE_WORD      = DEFAULT_BASE_WORD,
  parameter int          READ_LATENCY   = 4,
  parameter int          MAX_PENDING    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [29:0]           sdram_address,
  input  logic                  sdram_read,
  input  logic                  sdram_write,
  input  logic [WORD_WIDTH-1:0] sdram_writedata,
  output logic                  sdram_waitrequest,
  output logic [WORD_WIDTH-1:0] sdram_readdata,
  output logic                  sdram_readdatavalid,
  output logic                  range_error,
  output logic                  protocol_error
);

  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  logic [WORD_WIDTH-1:0]     mem [DEPTH];
  logic [29:0]               idx;
  logic [MEM_WORDS_LOG2-1:0] mem_idx;
  logic                      in_range;
  logic                      stall;
  logic                      accept_rd;
  logic                      accept_wr;
  logic [3:0]                pending;
  rd_entry_t                 pipe_in;
  rd_entry_t                 pipe_out;

  // Unsigned 30-bit offset; addresses below the base wrap to huge values.
  assign idx      = sdram_address - BASE_WORD;
  assign mem_idx  = idx[MEM_WORDS_LOG2-1:0];
  assign in_range = (idx >> MEM_WORDS_LOG2) == 30'd0;

`ifdef SDRAM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  // Free-running LFSR; stalls roughly one cycle in four.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign stall = lfsr[0] & lfsr[1];
`else
  assign stall = 1'b0;
`endif

  assign sdram_waitrequest = reset | (pending == 4'(MAX_PENDING)) | stall;

  // A read issued together with a write is ignored; the write wins.
  assign accept_rd = sdram_read & ~sdram_write & ~sdram_waitrequest;
  assign accept_wr = sdram_write & ~sdram_waitrequest;

  // Sample the array in the acceptance cycle so earlier writes are visible.
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = accept_rd;
    pipe_in.data  = in_range ? DATA_W'(mem[mem_idx]) : BAD_READ_DATA;
  end

  sdram_read_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clock    (clock),
    .flush    (reset),
    .in_entry (pipe_in),
    .out_entry(pipe_out)
  );

  assign sdram_readdatavalid = pipe_out.valid;
  assign sdram_readdata      = WORD_WIDTH'(pipe_out.data);

  // Backing store write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (accept_wr && in_range) begin
      mem[mem_idx] <= sdram_writedata;
    end
  end

  // In-flight read count: up on acceptance, down on each response.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending + {3'b0, accept_rd} - {3'b0, sdram_readdatavalid};
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      range_error    <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if ((accept_rd || accept_wr) && !in_range) begin
        range_error <= 1'b1;
      end
      if (sdram_read && sdram_write) begin
        protocol_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed scenarios plus a random
// read/write mix, with responses checked by a scoreboard monitor.
module tb_sdram_responder;
  import sdram_responder_pkg::*;

  localparam int          LAT    = 4;
  localparam int          MAXP   = 4;
  localparam logic [29:0] BASE   = 30'h0F800000;
  localparam int          WORDS  = 65536;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] sdram_address = '0;
  logic        sdram_read = 1'b0;
  logic        sdram_write = 1'b0;
  logic [31:0] sdram_writedata = '0;
  logic        sdram_waitrequest;
  logic [31:0] sdram_readdata;
  logic        sdram_readdatavalid;
  logic        range_error;
  logic        protocol_error;

  // Reference state: memory, sticky flags, outstanding responses.
  logic [31:0] mem_m [int];
  logic [31:0] exp_q [$];
  int          due_q [$];
  bit          range_exp = 0;
  bit          prot_exp = 0;
  int          pend_m = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          checks = 0;
  int          errors = 0;
  int          acc_cyc [8];
  bit          written [32];

  sdram_responder #(
    .WORD_WIDTH    (32),
    .MEM_WORDS_LOG2(16),
    .BASE_WORD     (BASE),
    .READ_LATENCY  (LAT),
    .MAX_PENDING   (MAXP)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .sdram_address      (sdram_address),
    .sdram_read         (sdram_read),
    .sdram_write        (sdram_write),
    .sdram_writedata    (sdram_writedata),
    .sdram_waitrequest  (sdram_waitrequest),
    .sdram_readdata     (sdram_readdata),
    .sdram_readdatavalid(sdram_readdatavalid),
    .range_error        (range_error),
    .protocol_error     (protocol_error)
  );

  // Clock and cycle counter.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Drive one request and hold it until accepted; update the model on accept.
  task automatic issue(input bit rd, input bit wr, input logic [29:0] addr,
                       input logic [31:0] data);
    int          guard;
    logic [29:0] idx;
    sdram_read      = rd;
    sdram_write     = wr;
    sdram_address   = addr;
    sdram_writedata = data;
    guard = 0;
    while (sdram_waitrequest && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    checks++;
    if (sdram_waitrequest) begin
      errors++;
      $display("FAIL accept_timeout: waitrequest stuck at 1, required 0 within 100 cycles");
    end else begin
      last_acc = cyc;
      idx = addr - BASE;
      if (rd && wr) prot_exp = 1;
      if (wr) begin
        if (idx < 30'(WORDS)) mem_m[int'(idx)] = data;
        else range_exp = 1;
      end else if (rd) begin
        if (idx < 30'(WORDS)) exp_q.push_back(mem_m[int'(idx)]);
        else begin
          exp_q.push_back(32'hDEADBEEF);
          range_exp = 1;
        end
        due_q.push_back(cyc + LAT);
        pend_m++;
      end
    end
    @(posedge clock); #1;
    sdram_read  = 1'b0;
    sdram_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (due_q.size() > 0 && g < 40) begin
      @(posedge clock); #1;
      g++;
    end
    check_int("drain_outstanding", due_q.size(), 0);
    check_int("pending_zero", pend_m, 0);
  endtask

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clock) begin
    logic [31:0] d;
    int          t;
    if (!reset) begin
      if (sdram_readdatavalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: readdatavalid=1 data %h at cycle %0d, required no response", sdram_readdata, cyc);
        end else begin
          d = exp_q.pop_front();
          t = due_q.pop_front();
          pend_m--;
          checks++;
          if (sdram_readdata !== d) begin
            errors++;
            $display("FAIL read_data: got %h required %h", sdram_readdata, d);
          end
          checks++;
          if (t != cyc) begin
            errors++;
            $display("FAIL read_latency: valid at cycle %0d required cycle %0d", cyc, t);
          end
        end
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: no response at cycle %0d, required data %h", cyc, exp_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        pend_m--;
      end
      checks++;
      if (pend_m < 0 || pend_m > MAXP) begin
        errors++;
        $display("FAIL pending_bound: outstanding %0d required 0..%0d", pend_m, MAXP);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [29:0] a;
    int          k;
    bit          rd;

    // Reset block.
    idle(1);
    check1("waitrequest_in_reset", sdram_waitrequest, 1'b1);
    idle(2);
    reset = 1'b0;
    #1;
    check1("waitrequest_after_reset", sdram_waitrequest, 1'b0);
    check1("rdv_after_reset", sdram_readdatavalid, 1'b0);
    checks++;
    if (sdram_readdata !== 32'h0) begin
      errors++;
      $display("FAIL readdata_after_reset: got %h required 00000000", sdram_readdata);
    end
    check1("range_after_reset", range_error, 1'b0);
    check1("protocol_after_reset", protocol_error, 1'b0);
    @(posedge clock); #1;

    // Write then read on the next cycle.
    issue(0, 1, BASE, 32'h12345678);
    issue(1, 0, BASE, 32'h0);
    drain();
    check1("range_clean", range_error, 1'b0);
    check1("protocol_clean", protocol_error, 1'b0);

    // Preload and eight back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      issue(0, 1, BASE + 30'(i), 32'(i * 3));
      written[i] = 1;
    end
    idle(2);
    for (int i = 0; i < 8; i++) begin
      sdram_read    = 1'b1;
      sdram_address = BASE + 30'(i);
      issue(1, 0, BASE + 30'(i), 32'h0);
      acc_cyc[i] = last_acc;
    end
`ifndef SDRAM_RESPONDER_STALL_EN
    check1("full_wait_cycle9", sdram_waitrequest, 1'b1);
    for (int i = 1; i < 8; i++) begin
      check_int("burst_accept_cycle", acc_cyc[i] - acc_cyc[0], i + ((i >= 4) ? 1 : 0));
    end
`endif
    drain();

    // Out-of-range read and write.
    issue(1, 0, 30'h00000010, 32'h0);
    drain();
    check1("range_after_bad_read", range_error, 1'b1);
    issue(0, 1, BASE + 30'h10000, 32'hA5A5A5A5);
    issue(0, 1, BASE + 30'd3, 32'h9);
    check1("range_sticky", range_error, range_exp);

    // Simultaneous read and write.
    issue(1, 1, BASE + 30'd2, 32'h55);
    idle(LAT + 4);
    check1("protocol_set", protocol_error, 1'b1);
    issue(1, 0, BASE + 30'd2, 32'h0);
    drain();

    // Reset in the middle of two in-flight reads.
    issue(1, 0, BASE + 30'd1, 32'h0);
    issue(1, 0, BASE + 30'd4, 32'h0);
    sdram_read    = 1'b1;
    sdram_address = BASE + 30'd5;
    reset         = 1'b1;
    #1;
    check1("waitrequest_mid_reset", sdram_waitrequest, 1'b1);
    exp_q.delete();
    due_q.delete();
    pend_m    = 0;
    range_exp = 0;
    prot_exp  = 0;
    @(posedge clock); #1;
    reset      = 1'b0;
    sdram_read = 1'b0;
    #1;
    check1("waitrequest_post_reset", sdram_waitrequest, 1'b0);
    check1("protocol_cleared", protocol_error, 1'b0);
    idle(LAT + 6);
    issue(1, 0, BASE + 30'd2, 32'h0);
    issue(1, 0, BASE + 30'd0, 32'h0);
    drain();

    // Random mix against the reference model.
    for (int n = 0; n < 400; n++) begin
      rd = ($urandom_range(0, 1) == 1);
      k  = $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) begin
        a = ($urandom_range(0, 1) == 1) ? (BASE - 30'($urandom_range(1, 8)))
                                        : (BASE + 30'(WORDS) + 30'($urandom_range(0, 8)));
      end else begin
        a = BASE + 30'(k);
        if (rd && !written[k]) rd = 0;
        if (!rd) written[k] = 1;
      end
      issue(rd, !rd, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    check1("range_after_random", range_error, range_exp);
    check1("protocol_after_random", protocol_error, prot_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
